// File: rtl/alu_sweep_checker_pkg.sv
// -----------------------------------------------------------------------------
// alu_sweep_checker_pkg
// Shared types for the ALU sweep checker:
//   - CPU word geometry and flag bit positions
//   - sweep FSM state enum, op-select enum, mode bit positions
//   - StrcInAlu / StrcOutAlu: the CPU ALU interface structs
//   - alu_eval(): the CPU ALU datapath exercised by the sweep
// -----------------------------------------------------------------------------
package alu_sweep_checker_pkg;

    localparam int CPU_W   = 8;
    localparam int FLAG_W  = 4;
    localparam int SHAMT_W = $clog2(CPU_W);

    // Flag vector layout {Z, C, N, V}
    localparam int FLG_Z = 3;
    localparam int FLG_C = 2;
    localparam int FLG_N = 1;
    localparam int FLG_V = 0;

    // mode input bit positions
    localparam int MODE_CMP_BIT = 0;
    localparam int MODE_ROT_BIT = 1;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_DRIVE   = 3'd1,
        ST_CHECK   = 3'd2,
        ST_ADVANCE = 3'd3,
        ST_FINISH  = 3'd4
    } state_e;

    // Encoding doubles as the first_err_op report value
    typedef enum logic [1:0] {
        OP_SUB = 2'd0,
        OP_ROL = 2'd1,
        OP_ROR = 2'd2
    } op_sel_e;

    typedef enum logic [1:0] {
        ALU_ADD = 2'd0,
        ALU_SUB = 2'd1,
        ALU_ROL = 2'd2,
        ALU_ROR = 2'd3
    } alu_oper_e;

    typedef struct packed {
        logic [CPU_W-1:0]  a_in;
        logic [CPU_W-1:0]  b_in;
        alu_oper_e         oper;
        logic [FLAG_W-1:0] flags_in;
    } StrcInAlu;

    typedef struct packed {
        logic [CPU_W-1:0]  result;
        logic [FLAG_W-1:0] flags;
    } StrcOutAlu;

    function automatic alu_oper_e to_alu_oper(input op_sel_e op);
        case (op)
            OP_SUB:  return ALU_SUB;
            OP_ROL:  return ALU_ROL;
            default: return ALU_ROR;
        endcase
    endfunction

    // CPU ALU. Arithmetic ops produce Z/C/N/V (C = no borrow on subtract);
    // rotates pass flags_in through unchanged.
    function automatic StrcOutAlu alu_eval(input StrcInAlu x);
        StrcOutAlu          o;
        logic [CPU_W:0]     wide;
        logic [SHAMT_W-1:0] sh;
        o    = '0;
        wide = '0;
        sh   = x.b_in[SHAMT_W-1:0];
        case (x.oper)
            ALU_ADD: begin
                wide            = {1'b0, x.a_in} + {1'b0, x.b_in};
                o.result        = wide[CPU_W-1:0];
                o.flags[FLG_C]  = wide[CPU_W];
                o.flags[FLG_V]  = (x.a_in[CPU_W-1] == x.b_in[CPU_W-1]) &&
                                  (o.result[CPU_W-1] != x.a_in[CPU_W-1]);
                o.flags[FLG_Z]  = (o.result == '0);
                o.flags[FLG_N]  = o.result[CPU_W-1];
            end
            ALU_SUB: begin
                wide            = {1'b0, x.a_in} - {1'b0, x.b_in};
                o.result        = wide[CPU_W-1:0];
                o.flags[FLG_C]  = ~wide[CPU_W];
                o.flags[FLG_V]  = (x.a_in[CPU_W-1] != x.b_in[CPU_W-1]) &&
                                  (o.result[CPU_W-1] != x.a_in[CPU_W-1]);
                o.flags[FLG_Z]  = (o.result == '0);
                o.flags[FLG_N]  = o.result[CPU_W-1];
            end
            ALU_ROL: begin
                o.result = (x.a_in << sh) | (x.a_in >> (CPU_W - int'(sh)));
                o.flags  = x.flags_in;
            end
            default: begin
                o.result = (x.a_in >> sh) | (x.a_in << (CPU_W - int'(sh)));
                o.flags  = x.flags_in;
            end
        endcase
        return o;
    endfunction

endpackage

// File: rtl/alu_sweep_checker_golden.sv
// -----------------------------------------------------------------------------
// alu_sweep_golden
// Combinational reference for one sweep check. Derives the expected
// behaviour from the raw WIDTH-bit operands and flags a mismatch against the
// observed ALU output.
//   op_i     : op under test (Sub / Rol / Ror)
//   a_i, b_i : WIDTH-bit sweep operands
//   res_i    : observed ALU result (after any fault injection)
//   flags_i  : observed ALU flags {Z,C,N,V}
//   err_o    : 1 when the observed output disagrees with the reference
// -----------------------------------------------------------------------------
module alu_sweep_golden
    import alu_sweep_checker_pkg::*;
#(
    parameter int WIDTH = 4
) (
    input  op_sel_e             op_i,
    input  logic [WIDTH-1:0]    a_i,
    input  logic [WIDTH-1:0]    b_i,
    input  logic [CPU_W-1:0]    res_i,
    input  logic [FLAG_W-1:0]   flags_i,
    output logic                err_o
);

    logic [CPU_W-1:0]   ax_s, bx_s, ax_u, bx_u, rot_exp;
    logic [2*CPU_W-1:0] dbl;
    logic               lt_signed;

    always_comb begin
        ax_s      = CPU_W'($signed(a_i));
        bx_s      = CPU_W'($signed(b_i));
        ax_u      = CPU_W'(a_i);
        bx_u      = CPU_W'(b_i);
        lt_signed = ($signed(ax_s) < $signed(bx_s));
        dbl       = '0;
        rot_exp   = '0;
        err_o     = 1'b0;
        case (op_i)
            OP_SUB: begin
                // Any combination of flag mismatches is a single failure
                err_o = (flags_i[FLG_Z] != (ax_s == bx_s)) ||
                        (flags_i[FLG_C] != (ax_s >= bx_s)) ||
                        ((flags_i[FLG_N] ^ flags_i[FLG_V]) != lt_signed);
            end
            OP_ROL: begin
                // Doubled word shifted left: upper half is the rotation
                dbl     = {ax_u, ax_u} << (bx_u % CPU_W);
                rot_exp = dbl[2*CPU_W-1:CPU_W];
                err_o   = (res_i != rot_exp);
            end
            OP_ROR: begin
                dbl     = {ax_u, ax_u} >> (bx_u % CPU_W);
                rot_exp = dbl[CPU_W-1:0];
                err_o   = (res_i != rot_exp);
            end
            default: err_o = 1'b0;
        endcase
    end

endmodule

// File: rtl/alu_sweep_checker.sv
// -----------------------------------------------------------------------------
// alu_sweep_checker
// Exhaustive self-test of the CPU ALU: sweeps every (a, b) pair of WIDTH-bit
// operands through the enabled ops, compares each ALU output against
// alu_sweep_golden and keeps a saturating error count plus the first failure.
// Ports:
//   clk, rst_n        : clock, asynchronous active-low reset
//   start             : begin a sweep (IDLE only)
//   mode[1:0]         : bit0 compare (Sub) checks, bit1 rotate (Rol, Ror) checks
//   abort             : cancel a running sweep without a done pulse
//   fault_inj         : invert result bit 0 before checking
//   busy              : sweep in progress
//   done              : one-cycle pulse on sweep completion
//   err_count         : failing checks this run, saturating
//   first_err_valid   : first-failure capture is populated
//   first_err_a/b/op  : operands and op of the first failure
// -----------------------------------------------------------------------------
module alu_sweep_checker
    import alu_sweep_checker_pkg::*;
#(
    parameter int WIDTH     = 4,
    parameter int ERR_CNT_W = 16
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 start,
    input  logic [1:0]           mode,
    input  logic                 abort,
    input  logic                 fault_inj,
    output logic                 busy,
    output logic                 done,
    output logic [ERR_CNT_W-1:0] err_count,
    output logic                 first_err_valid,
    output logic [WIDTH-1:0]     first_err_a,
    output logic [WIDTH-1:0]     first_err_b,
    output logic [1:0]           first_err_op
);

    state_e               state_q, state_d;
    logic [WIDTH-1:0]     a_q, a_d, b_q, b_d;
    op_sel_e              op_q, op_d;
    logic [1:0]           mode_q, mode_d;
    logic                 fault_q, fault_d;
    logic [ERR_CNT_W-1:0] err_cnt_q, err_cnt_d;
    logic                 fe_valid_q, fe_valid_d;
    logic [WIDTH-1:0]     fe_a_q, fe_a_d, fe_b_q, fe_b_d;
    op_sel_e              fe_op_q, fe_op_d;
    StrcInAlu             alu_in_q, alu_in_d;
    StrcOutAlu            alu_out;
    logic [CPU_W-1:0]     res_chk;
    logic                 chk_err;
    logic                 have_next;
    op_sel_e              next_op;
    logic                 last_vec;

    function automatic op_sel_e first_op(input logic [1:0] m);
        return m[MODE_CMP_BIT] ? OP_SUB : OP_ROL;
    endfunction

    assign alu_out = alu_eval(alu_in_q);
    assign res_chk = alu_out.result ^ CPU_W'(fault_q);

    // a_q/b_q/op_q are stable through CHECK, so they describe exactly the
    // vector that was loaded into alu_in_q during DRIVE.
    alu_sweep_golden #(
        .WIDTH (WIDTH)
    ) u_golden (
        .op_i    (op_q),
        .a_i     (a_q),
        .b_i     (b_q),
        .res_i   (res_chk),
        .flags_i (alu_out.flags),
        .err_o   (chk_err)
    );

    // Op sequencing within one vector: Sub -> Rol -> Ror, skipping disabled ops
    always_comb begin
        have_next = 1'b0;
        next_op   = OP_ROL;
        case (op_q)
            OP_SUB: have_next = mode_q[MODE_ROT_BIT];
            OP_ROL: begin
                have_next = 1'b1;
                next_op   = OP_ROR;
            end
            default: have_next = 1'b0;
        endcase
    end

    assign last_vec = (&a_q) && (&b_q);

    always_comb begin
        state_d    = state_q;
        a_d        = a_q;
        b_d        = b_q;
        op_d       = op_q;
        mode_d     = mode_q;
        fault_d    = fault_q;
        err_cnt_d  = err_cnt_q;
        fe_valid_d = fe_valid_q;
        fe_a_d     = fe_a_q;
        fe_b_d     = fe_b_q;
        fe_op_d    = fe_op_q;
        alu_in_d   = alu_in_q;

        case (state_q)
            ST_IDLE: begin
                // start outranks a simultaneous abort here
                if (start) begin
                    mode_d     = mode;
                    fault_d    = fault_inj;
                    err_cnt_d  = '0;
                    fe_valid_d = 1'b0;
                    fe_a_d     = '0;
                    fe_b_d     = '0;
                    fe_op_d    = OP_SUB;
                    a_d        = '0;
                    b_d        = '0;
                    op_d       = first_op(mode);
                    state_d    = (mode == 2'b00) ? ST_FINISH : ST_DRIVE;
                end
            end
            ST_DRIVE: begin
                // Compare uses sign-extended operands, rotates zero-extended
                alu_in_d.a_in     = (op_q == OP_SUB) ? CPU_W'($signed(a_q)) : CPU_W'(a_q);
                alu_in_d.b_in     = (op_q == OP_SUB) ? CPU_W'($signed(b_q)) : CPU_W'(b_q);
                alu_in_d.oper     = to_alu_oper(op_q);
                alu_in_d.flags_in = '0;
                state_d           = abort ? ST_IDLE : ST_CHECK;
            end
            ST_CHECK: begin
                if (chk_err) begin
                    if (!(&err_cnt_q)) begin
                        err_cnt_d = err_cnt_q + 1'b1;
                    end
                    if (!fe_valid_q) begin
                        fe_valid_d = 1'b1;
                        fe_a_d     = a_q;
                        fe_b_d     = b_q;
                        fe_op_d    = op_q;
                    end
                end
                // Advance is folded into this cycle so it costs no extra clock
                if (have_next) begin
                    op_d = next_op;
                end else begin
                    op_d = first_op(mode_q);
                    if (&b_q) begin
                        b_d = '0;
                        a_d = a_q + 1'b1;
                    end else begin
                        b_d = b_q + 1'b1;
                    end
                end
                if (abort) begin
                    state_d = ST_IDLE;
                end else if (!have_next && last_vec) begin
                    state_d = ST_FINISH;
                end else begin
                    state_d = ST_DRIVE;
                end
            end
            ST_ADVANCE: begin
                state_d = abort ? ST_IDLE : ST_DRIVE;
            end
            ST_FINISH: begin
                state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_IDLE;
            a_q        <= '0;
            b_q        <= '0;
            op_q       <= OP_SUB;
            mode_q     <= '0;
            fault_q    <= 1'b0;
            err_cnt_q  <= '0;
            fe_valid_q <= 1'b0;
            fe_a_q     <= '0;
            fe_b_q     <= '0;
            fe_op_q    <= OP_SUB;
            alu_in_q   <= '0;
        end else begin
            state_q    <= state_d;
            a_q        <= a_d;
            b_q        <= b_d;
            op_q       <= op_d;
            mode_q     <= mode_d;
            fault_q    <= fault_d;
            err_cnt_q  <= err_cnt_d;
            fe_valid_q <= fe_valid_d;
            fe_a_q     <= fe_a_d;
            fe_b_q     <= fe_b_d;
            fe_op_q    <= fe_op_d;
            alu_in_q   <= alu_in_d;
        end
    end

    assign busy            = (state_q == ST_DRIVE) || (state_q == ST_CHECK) ||
                             (state_q == ST_ADVANCE);
    assign done            = (state_q == ST_FINISH);
    assign err_count       = err_cnt_q;
    assign first_err_valid = fe_valid_q;
    assign first_err_a     = fe_a_q;
    assign first_err_b     = fe_b_q;
    assign first_err_op    = fe_op_q;

endmodule

// File: tb/tb_alu_sweep_checker.sv
module tb_alu_sweep_checker;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst_n;
    logic [1:0] mode;
    logic       abort;
    logic       fault_inj;
    logic       start0, start1, start2;

    // Instance 0: WIDTH=2, ERR_CNT_W=16
    logic        busy0, done0, fev0;
    logic [15:0] err0;
    logic [1:0]  fea0, feb0, feop0;
    // Instance 1: WIDTH=4, ERR_CNT_W=16
    logic        busy1, done1, fev1;
    logic [15:0] err1;
    logic [3:0]  fea1, feb1;
    logic [1:0]  feop1;
    // Instance 2: WIDTH=2, ERR_CNT_W=3
    logic        busy2, done2, fev2;
    logic [2:0]  err2;
    logic [1:0]  fea2, feb2, feop2;

    alu_sweep_checker #(.WIDTH(2), .ERR_CNT_W(16)) dut0 (
        .clk(clk), .rst_n(rst_n), .start(start0), .mode(mode), .abort(abort),
        .fault_inj(fault_inj), .busy(busy0), .done(done0), .err_count(err0),
        .first_err_valid(fev0), .first_err_a(fea0), .first_err_b(feb0),
        .first_err_op(feop0));

    alu_sweep_checker #(.WIDTH(4), .ERR_CNT_W(16)) dut1 (
        .clk(clk), .rst_n(rst_n), .start(start1), .mode(mode), .abort(abort),
        .fault_inj(fault_inj), .busy(busy1), .done(done1), .err_count(err1),
        .first_err_valid(fev1), .first_err_a(fea1), .first_err_b(feb1),
        .first_err_op(feop1));

    alu_sweep_checker #(.WIDTH(2), .ERR_CNT_W(3)) dut2 (
        .clk(clk), .rst_n(rst_n), .start(start2), .mode(mode), .abort(abort),
        .fault_inj(fault_inj), .busy(busy2), .done(done2), .err_count(err2),
        .first_err_valid(fev2), .first_err_a(fea2), .first_err_b(feb2),
        .first_err_op(feop2));

    typedef struct {
        int busy;
        int err;
        int fev;
        int fea;
        int feb;
        int feop;
    } exp_t;

    exp_t sb_q[$];

    int checks   = 0;
    int failures = 0;

    int s_busy, s_done, s_err, s_fev, s_fea, s_feb, s_feop;

    task automatic check(input string tag, input int obs, input int exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic sample(input int w);
        case (w)
            0: begin
                s_busy = int'(busy0); s_done = int'(done0); s_err = int'(err0);
                s_fev = int'(fev0); s_fea = int'(fea0); s_feb = int'(feb0); s_feop = int'(feop0);
            end
            1: begin
                s_busy = int'(busy1); s_done = int'(done1); s_err = int'(err1);
                s_fev = int'(fev1); s_fea = int'(fea1); s_feb = int'(feb1); s_feop = int'(feop1);
            end
            default: begin
                s_busy = int'(busy2); s_done = int'(done2); s_err = int'(err2);
                s_fev = int'(fev2); s_fea = int'(fea2); s_feb = int'(feb2); s_feop = int'(feop2);
            end
        endcase
    endtask

    task automatic set_start(input int w, input logic v);
        case (w)
            0:       start0 = v;
            1:       start1 = v;
            default: start2 = v;
        endcase
    endtask

    // Expected outcome of a full sweep. Every (a,b) pair runs each enabled
    // op for two cycles. With fault injection every rotate check fails
    // (result bit 0 flipped); compare checks only look at flags. The first
    // failure is therefore the Rol of a=0, b=0.
    function automatic exp_t model(input logic [1:0] m, input logic f,
                                   input int width, input int ecw);
        exp_t e;
        int vecs, nops, raw, sat;
        vecs   = 1 << (2 * width);
        nops   = int'(m[0]) + 2 * int'(m[1]);
        raw    = (f && m[1]) ? 2 * vecs : 0;
        sat    = (1 << ecw) - 1;
        e.busy = 2 * vecs * nops;
        e.err  = (raw > sat) ? sat : raw;
        e.fev  = (raw > 0) ? 1 : 0;
        e.fea  = 0;
        e.feb  = 0;
        e.feop = (raw > 0) ? 1 : 0;
        return e;
    endfunction

    // Full sweep: push expectation at start, pop and compare on done.
    // mid >= 0 re-pulses start (with inverted mode/fault) at that busy cycle.
    task automatic run(input int w, input logic [1:0] m, input logic f,
                       input int width, input int ecw, input int mid,
                       input logic with_abort, input string tag);
        exp_t e;
        int   cnt;
        int   got;
        sb_q.push_back(model(m, f, width, ecw));
        @(negedge clk);
        mode = m; fault_inj = f; abort = with_abort;
        set_start(w, 1'b1);
        @(negedge clk);
        set_start(w, 1'b0);
        abort = 1'b0;
        cnt = 0;
        got = 0;
        for (int i = 0; i < 2000; i++) begin
            sample(w);
            if (s_done == 1) begin
                got = 1;
                break;
            end
            if (s_busy == 1) cnt++;
            set_start(w, 1'b0);
            if (cnt == mid) begin
                set_start(w, 1'b1);
                mode = ~m;
                fault_inj = ~f;
            end
            @(negedge clk);
        end
        set_start(w, 1'b0);
        mode = m;
        fault_inj = f;
        e = sb_q.pop_front();
        check({tag, "_done_seen"}, got, 1);
        check({tag, "_busy_cycles"}, cnt, e.busy);
        check({tag, "_err_count"}, s_err, e.err);
        check({tag, "_first_err_valid"}, s_fev, e.fev);
        check({tag, "_first_err_a"}, s_fea, e.fea);
        check({tag, "_first_err_b"}, s_feb, e.feb);
        check({tag, "_first_err_op"}, s_feop, e.feop);
        @(negedge clk);
        sample(w);
        check({tag, "_done_one_cycle"}, s_done, 0);
        check({tag, "_idle_after"}, s_busy, 0);
    endtask

    initial begin
        int cnt;
        int saw_done;
        int saw_busy;

        rst_n = 1'b0; mode = 2'b00; abort = 1'b0; fault_inj = 1'b0;
        start0 = 1'b0; start1 = 1'b0; start2 = 1'b0;

        repeat (3) @(negedge clk);
        sample(0);
        check("reset_busy", s_busy, 0);
        check("reset_done", s_done, 0);
        check("reset_err", s_err, 0);
        check("reset_fev", s_fev, 0);
        check("reset_feop", s_feop, 0);
        rst_n = 1'b1;
        @(negedge clk);

        // Compare only; a mid-run start with different mode/fault is ignored
        run(0, 2'b01, 1'b0, 2, 16, 10, 1'b0, "w2_cmp");
        run(0, 2'b11, 1'b0, 2, 16, -1, 1'b0, "w2_all");
        run(0, 2'b10, 1'b1, 2, 16, -1, 1'b0, "w2_rot_fault");
        // mode 00: straight to done; also clears the previous error count
        run(0, 2'b00, 1'b1, 2, 16, -1, 1'b0, "w2_mode0");
        // abort together with start in IDLE: start wins
        run(0, 2'b01, 1'b0, 2, 16, -1, 1'b1, "w2_abort_start");
        run(2, 2'b10, 1'b1, 2, 3, -1, 1'b0, "w2_sat");

        // Abort at busy cycle 20 on the WIDTH=4 instance
        @(negedge clk);
        mode = 2'b01; fault_inj = 1'b0;
        start1 = 1'b1;
        @(negedge clk);
        start1 = 1'b0;
        cnt = 0;
        for (int i = 0; i < 200; i++) begin
            sample(1);
            if (s_busy == 1) cnt++;
            if (cnt == 20) break;
            @(negedge clk);
        end
        check("w4_abort_reach20", cnt, 20);
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        sample(1);
        check("w4_abort_busy", s_busy, 0);
        check("w4_abort_done", s_done, 0);
        check("w4_abort_err", s_err, 0);
        saw_done = 0;
        saw_busy = 0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            sample(1);
            if (s_done == 1) saw_done = 1;
            if (s_busy == 1) saw_busy = 1;
        end
        check("w4_abort_no_done", saw_done, 0);
        check("w4_abort_stays_idle", saw_busy, 0);

        // Asynchronous reset in the middle of a failing sweep
        @(negedge clk);
        mode = 2'b10; fault_inj = 1'b1;
        start0 = 1'b1;
        @(negedge clk);
        start0 = 1'b0;
        for (int i = 0; i < 100; i++) begin
            if (fev0 == 1'b1) break;
            @(negedge clk);
        end
        repeat (3) @(negedge clk);
        sample(0);
        check("rstmid_pre_fev", s_fev, 1);
        check("rstmid_pre_busy", s_busy, 1);
        #2 rst_n = 1'b0;
        #1 sample(0);
        check("rstmid_busy", s_busy, 0);
        check("rstmid_done", s_done, 0);
        check("rstmid_err", s_err, 0);
        check("rstmid_fev", s_fev, 0);
        check("rstmid_fea", s_fea, 0);
        check("rstmid_feb", s_feb, 0);
        check("rstmid_feop", s_feop, 0);
        @(negedge clk);
        rst_n = 1'b1;
        saw_done = 0;
        saw_busy = 0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            sample(0);
            if (s_done == 1) saw_done = 1;
            if (s_busy == 1) saw_busy = 1;
        end
        check("rstmid_no_done", saw_done, 0);
        check("rstmid_stays_idle", saw_busy, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
